// File: rtl/seq_mult_pkg.sv
// ---------------------------------------------------------------------------
// seq_mult_pkg
//   Shared types and helpers for the parametrised shift-add multiplier.
//   - state_t   : controller states (IDLE / BUSY / DONE)
//   - mag_t     : wide scratch type used for sign extension / magnitude
//   - steps     : number of BUSY cycles without early exit (WIDTH/BPC)
//   - cnt_width : width of the step counter, $clog2(WIDTH/BPC+1)
//   - abs_mag   : magnitude of an operand given the signed/unsigned mode
// ---------------------------------------------------------------------------
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Upper bound on operand width supported by abs_mag's scratch type.
    localparam int MAX_WIDTH = 256;

    typedef logic [MAX_WIDTH-1:0] mag_t;

    function automatic int steps(input int width, input int bpc);
        return width / bpc;
    endfunction

    function automatic int cnt_width(input int width, input int bpc);
        return $clog2(width / bpc + 1);
    endfunction

    // The caller passes the operand already extended to MAX_WIDTH (sign-
    // extended when signed_mode is set). Negating in the wide domain and
    // truncating back to WIDTH maps -2^(WIDTH-1) onto 2^(WIDTH-1) cleanly.
    function automatic mag_t abs_mag(input mag_t value, input logic signed_mode);
        if (signed_mode && value[MAX_WIDTH-1]) begin
            return -value;
        end
        return value;
    endfunction

endpackage

// File: rtl/seq_mult_pp.sv
// ---------------------------------------------------------------------------
// seq_mult_pp
//   Combinational partial-product generator: o_pp = i_digit * i_mcand,
//   formed as the sum of i_mcand shifted by j for every set bit j of the
//   BPC-bit digit. Result is truncated to 2*WIDTH bits; the caller guarantees
//   the true value fits.
//
//   Ports:
//     i_digit  in  BPC        multiplier digit
//     i_mcand  in  2*WIDTH    already-shifted multiplicand
//     o_pp     out 2*WIDTH    partial product
// ---------------------------------------------------------------------------
module seq_mult_pp #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic [BPC-1:0]     i_digit,
    input  logic [2*WIDTH-1:0] i_mcand,
    output logic [2*WIDTH-1:0] o_pp
);

    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output
        // a default first, so the running sum is well defined and no latch
        // is inferred.
        o_pp = '0;
        for (int j = 0; j < BPC; j++) begin
            if (i_digit[j]) begin
                o_pp = o_pp + (i_mcand << j);
            end
        end
    end

endmodule

// File: rtl/seq_mult_param.sv
// ---------------------------------------------------------------------------
// seq_mult_param
//   Iterative shift-add multiplier with valid/ready handshakes.
//   Operands are captured in IDLE (as magnitudes plus a result sign when
//   signed_mode=1), BPC multiplier bits are retired per BUSY cycle, and the
//   sign-corrected 2*WIDTH product is held in DONE until the consumer
//   accepts it.
//
//   Parameters:
//     WIDTH       operand width (>= 2)
//     BPC         multiplier bits per BUSY cycle (1, 2 or 4; divides WIDTH)
//     EARLY_EXIT  1 = stop once the remaining multiplier is zero
//
//   Ports:
//     clk, rst_n    clock (rising edge), asynchronous active-low reset
//     in_valid      operand pair valid         in_ready   can accept operands
//     a, b          multiplicand / multiplier  signed_mode two's complement op
//     out_valid     product valid              out_ready  consumer accepts
//     product       registered 2*WIDTH result  busy       high while BUSY
// ---------------------------------------------------------------------------
module seq_mult_param
    import seq_mult_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int BPC        = 1,
    parameter int EARLY_EXIT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int STEPS = steps(WIDTH, BPC);
    localparam int CNT_W = cnt_width(WIDTH, BPC);

    if (!((BPC == 1) || (BPC == 2) || (BPC == 4)) || (WIDTH % BPC != 0) ||
        (WIDTH < 2) || (WIDTH > MAX_WIDTH)) begin : g_param_error
        $error("seq_mult_param: illegal parameters WIDTH=%0d BPC=%0d", WIDTH, BPC);
    end

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_next;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_product;
    logic [WIDTH-1:0]   r_mplr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic               r_out_valid;

    // -----------------------------------------------------------------------
    // Combinational datapath
    // -----------------------------------------------------------------------
    mag_t               w_a_ext;
    mag_t               w_b_ext;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_neg;
    logic [2*WIDTH-1:0] w_pp;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_product_next;
    logic [WIDTH-1:0]   w_mplr_next;
    logic               w_accept;
    logic               w_last;

    // Sign extension happens inside the size cast of the $signed operand.
    always_comb begin
        w_a_ext = mag_t'(a);
        w_b_ext = mag_t'(b);
        if (signed_mode) begin
            w_a_ext = mag_t'($signed(a));
            w_b_ext = mag_t'($signed(b));
        end
    end

    assign w_a_mag = WIDTH'(abs_mag(w_a_ext, signed_mode));
    assign w_b_mag = WIDTH'(abs_mag(w_b_ext, signed_mode));
    assign w_neg   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);

    seq_mult_pp #(
        .WIDTH (WIDTH),
        .BPC   (BPC)
    ) u_pp (
        .i_digit (r_mplr[BPC-1:0]),
        .i_mcand (r_mcand),
        .o_pp    (w_pp)
    );

    assign w_acc_next     = r_acc + w_pp;
    assign w_mplr_next    = r_mplr >> BPC;
    assign w_product_next = r_neg ? -w_acc_next : w_acc_next;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking '<=' so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        in_ready     = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                // Early exit looks at the multiplier after this cycle's shift:
                // once it is zero, no later digit can add anything.
                if ((r_cnt == CNT_W'(STEPS - 1)) ||
                    ((EARLY_EXIT != 0) && (w_mplr_next == '0))) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (r_out_valid && out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand     <= '0;
            r_acc       <= '0;
            r_mplr      <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_product   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mcand <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mplr  <= w_b_mag;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_neg   <= w_neg;
                    end
                end
                BUSY: begin
                    r_acc   <= w_acc_next;
                    r_mcand <= r_mcand << BPC;
                    r_mplr  <= w_mplr_next;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_product   <= w_product_next;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // product is left untouched so it keeps its last value.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign product   = r_product;

endmodule

// File: tb/tb_seq_mult_param.sv
// ---------------------------------------------------------------------------
// tb_seq_mult_param
//   Four multiplier configurations side by side:
//     0: WIDTH=32 BPC=1 EARLY_EXIT=0     1: WIDTH=32 BPC=1 EARLY_EXIT=1
//     2: WIDTH=16 BPC=4 EARLY_EXIT=0     3: WIDTH=16 BPC=2 EARLY_EXIT=1
//   Expected products and latencies come from plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_seq_mult_param;

    logic        clk;
    logic        rst_n;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_sm;
    logic        r_in_valid  [4];
    logic        r_out_ready [4];
    logic        w_in_ready  [4];
    logic        w_out_valid [4];
    logic        w_busy      [4];
    logic [63:0] w_prod0;
    logic [63:0] w_prod1;
    logic [31:0] w_prod2;
    logic [31:0] w_prod3;

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    seq_mult_param #(.WIDTH(32), .BPC(1), .EARLY_EXIT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid[0]), .in_ready(w_in_ready[0]),
        .a(r_a), .b(r_b), .signed_mode(r_sm), .out_valid(w_out_valid[0]),
        .out_ready(r_out_ready[0]), .product(w_prod0), .busy(w_busy[0]));

    seq_mult_param #(.WIDTH(32), .BPC(1), .EARLY_EXIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid[1]), .in_ready(w_in_ready[1]),
        .a(r_a), .b(r_b), .signed_mode(r_sm), .out_valid(w_out_valid[1]),
        .out_ready(r_out_ready[1]), .product(w_prod1), .busy(w_busy[1]));

    seq_mult_param #(.WIDTH(16), .BPC(4), .EARLY_EXIT(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid[2]), .in_ready(w_in_ready[2]),
        .a(r_a[15:0]), .b(r_b[15:0]), .signed_mode(r_sm), .out_valid(w_out_valid[2]),
        .out_ready(r_out_ready[2]), .product(w_prod2), .busy(w_busy[2]));

    seq_mult_param #(.WIDTH(16), .BPC(2), .EARLY_EXIT(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid[3]), .in_ready(w_in_ready[3]),
        .a(r_a[15:0]), .b(r_b[15:0]), .signed_mode(r_sm), .out_valid(w_out_valid[3]),
        .out_ready(r_out_ready[3]), .product(w_prod3), .busy(w_busy[3]));

    function automatic int cfg_w(input int idx);
        return (idx < 2) ? 32 : 16;
    endfunction

    function automatic int cfg_bpc(input int idx);
        case (idx)
            2:       return 4;
            3:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int cfg_ee(input int idx);
        return (idx == 1 || idx == 3) ? 1 : 0;
    endfunction

    function automatic logic [63:0] prod_of(input int idx);
        case (idx)
            0:       return w_prod0;
            1:       return w_prod1;
            2:       return {32'd0, w_prod2};
            default: return {32'd0, w_prod3};
        endcase
    endfunction

    // Reference product: interpret the operands as integers and multiply.
    function automatic logic [63:0] ref_prod(input int w, input logic [31:0] a,
                                             input logic [31:0] b, input logic sm);
        logic [63:0] mask;
        longint      sa;
        longint      sb;
        longint      p;
        mask = (64'd1 << w) - 64'd1;
        sa   = longint'(64'(a) & mask);
        sb   = longint'(64'(b) & mask);
        if (sm && sa[w-1]) sa = sa - (longint'(1) << w);
        if (sm && sb[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        if (2 * w < 64) p = p & ((longint'(1) << (2 * w)) - 1);
        return 64'(p);
    endfunction

    // Reference latency: full step count, or with early exit the number of
    // BPC-bit digits needed to cover |b| (at least one).
    function automatic int ref_lat(input int idx, input logic [31:0] b, input logic sm);
        int          w;
        int          bpc;
        int          bl;
        int          k;
        logic [63:0] mag;
        w   = cfg_w(idx);
        bpc = cfg_bpc(idx);
        if (cfg_ee(idx) == 0) return w / bpc;
        mag = 64'(b) & ((64'd1 << w) - 64'd1);
        if (sm && mag[w-1]) mag = (64'd1 << w) - mag;
        bl = 0;
        while (mag != 64'd0) begin
            bl++;
            mag = mag >> 1;
        end
        k = (bl + bpc - 1) / bpc;
        return (k < 1) ? 1 : k;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction on instance idx. Entered between clock edges.
    task automatic run_op(input int idx, input logic [31:0] op_a, input logic [31:0] op_b,
                          input logic sm, input logic [63:0] exp_p, input int exp_k,
                          input int hold, input logic early_ready, input string tag);
        int k;
        r_a                 = op_a;
        r_b                 = op_b;
        r_sm                = sm;
        r_in_valid[idx]     = 1'b1;
        r_out_ready[idx]    = early_ready;
        check({tag, " ready_before"}, 64'(w_in_ready[idx]), 64'd1);
        @(posedge clk);
        #1;
        r_in_valid[idx] = 1'b0;
        r_a             = $urandom;
        r_b             = $urandom;
        r_sm            = ~sm;
        k = 0;
        while (!w_out_valid[idx] && k < 200) begin
            check({tag, " busy_flags"}, {62'd0, w_in_ready[idx], w_busy[idx]}, 64'd1);
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, " out_valid"}, 64'(w_out_valid[idx]), 64'd1);
        check({tag, " latency"}, 64'(k), 64'(exp_k));
        check({tag, " product"}, prod_of(idx), exp_p);
        check({tag, " done_flags"}, {62'd0, w_in_ready[idx], w_busy[idx]}, 64'd0);
        for (int i = 0; i < hold; i++) begin
            r_in_valid[idx] = 1'b1;
            @(posedge clk);
            #1;
            check({tag, " hold_valid"}, 64'(w_out_valid[idx]), 64'd1);
            check({tag, " hold_product"}, prod_of(idx), exp_p);
            check({tag, " hold_flags"}, {62'd0, w_in_ready[idx], w_busy[idx]}, 64'd0);
        end
        r_in_valid[idx]  = 1'b0;
        r_out_ready[idx] = 1'b1;
        @(posedge clk);
        #1;
        r_out_ready[idx] = 1'b0;
        check({tag, " post_valid"}, 64'(w_out_valid[idx]), 64'd0);
        check({tag, " post_ready"}, 64'(w_in_ready[idx]), 64'd1);
        check({tag, " post_product"}, prod_of(idx), exp_p);
    endtask

    task automatic run_rand(input int idx, input int n);
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic        er;
        for (int i = 0; i < n; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            rs = 1'($urandom_range(0, 1));
            er = 1'($urandom_range(0, 1));
            run_op(idx, ra, rb, rs, ref_prod(cfg_w(idx), ra, rb, rs), ref_lat(idx, rb, rs),
                   int'($urandom_range(0, 2)) * int'(!er), er, $sformatf("rand%0d_%0d", idx, i));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        r_a   = '0;
        r_b   = '0;
        r_sm  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r_in_valid[i]  = 1'b0;
            r_out_ready[i] = 1'b0;
        end
        #12;
        check("reset out_valid", 64'(w_out_valid[0]), 64'd0);
        check("reset product", w_prod0, 64'd0);
        check("reset busy", 64'(w_busy[0]), 64'd0);
        check("reset in_ready", 64'(w_in_ready[0]), 64'd1);
        check("reset product16", {32'd0, w_prod2}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 32, 0, 1'b0, "max_unsigned");
        run_op(0, 32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 32, 5, 1'b0, "signed_neg3x5_bp");
        run_op(0, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 32, 0, 1'b0, "signed_minxmin");
        run_op(1, 32'h0000_1234, 32'h0000_0003, 1'b0, 64'h0000_0000_0000_369C, 2, 0, 1'b0, "early_x3");
        run_op(1, 32'h0000_1234, 32'h0000_0000, 1'b0, 64'h0, 1, 0, 1'b1, "early_x0");
        run_op(2, 32'h0000_ABCD, 32'h0000_1234, 1'b0, 64'h0000_0000_0C37_4FA4, 4, 0, 1'b0, "bpc4_w16");
        run_op(3, 32'h0000_8000, 32'h0000_8000, 1'b1, 64'h0000_0000_4000_0000, 8, 0, 1'b0, "bpc2_minxmin");

        // Reset while BUSY at cnt=10
        r_a           = 32'hFFFF_FFFF;
        r_b           = 32'hFFFF_FFFF;
        r_sm          = 1'b0;
        r_in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        r_in_valid[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_busy busy", 64'(w_busy[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst out_valid", 64'(w_out_valid[0]), 64'd0);
        check("async_rst product", w_prod0, 64'd0);
        check("async_rst busy", 64'(w_busy[0]), 64'd0);
        check("async_rst in_ready", 64'(w_in_ready[0]), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(0, 32'h0001_0001, 32'h0000_FFFF, 1'b0, 64'h0000_0000_FFFF_FFFF, 32, 0, 1'b0, "after_reset");

        // Randomised cases against the reference model
        run_rand(0, 4);
        run_rand(1, 8);
        run_rand(2, 8);
        run_rand(3, 16);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mult_param.md
Name: seq_mult_param

Overview:
Parametrised iterative shift-add multiplier, the successor to the fixed 32-bit unit. Adds the following over the fixed unit:
- configurable operand width
- configurable bits retired per cycle (radix)
- per-operation signed/unsigned mode
- optional early termination
- valid/ready handshakes on input and output, so it sits directly on datapath streams and supports backpressure

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH; legal range WIDTH >= 2
BPC, 1, multiplier bits retired per BUSY cycle; legal values 1, 2, 4; WIDTH % BPC == 0
EARLY_EXIT, 1, 1 = finish as soon as the remaining multiplier magnitude is zero; 0 = fixed latency

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands
a  in  WIDTH  multiplicand
b  in  WIDTH  multiplier
signed_mode  in  1  1 = operands are two's complement; sampled with a/b
out_valid  out  1  product valid
out_ready  in  1  consumer accepts product
product  out  2*WIDTH  result, registered
busy  out  1  high in BUSY state

Behaviour:
- Reset is asynchronous, active-low, on rst_n, clocked by clk.
- Reset values: state=IDLE, out_valid=0, product=0, busy=0, in_ready=1 (in_ready decodes combinationally from IDLE).
- FSM states are IDLE, BUSY and DONE.

IDLE:
- in_ready=1.
- On in_valid && in_ready, capture operands and go to BUSY, with cnt=0 and acc=0.
- If signed_mode=1: store |a| and |b| as WIDTH-bit unsigned magnitudes, and neg = a[MSB]^b[MSB].
  - -2^(WIDTH-1) maps to magnitude 2^(WIDTH-1); no overflow.
- If signed_mode=0: store operands raw, neg=0.

BUSY:
- in_ready=0.
- Each cycle: acc += digit * mcand_sh, where digit is the low BPC bits of the multiplier register.
- Then mcand_sh <<= BPC (2*WIDTH wide), mplr >>= BPC, and cnt++.
- Go to DONE when cnt == WIDTH/BPC-1, or when EARLY_EXIT=1 and the shifted mplr == 0, whichever comes first.
- On the transition to DONE: product <= neg ? -(acc_next) : acc_next, mod 2^(2*WIDTH), and out_valid <= 1.

DONE:
- out_valid=1. product and out_valid hold stable until out_valid && out_ready.
- On handshake: go to IDLE, out_valid <= 0. product keeps its last value.
- in_ready=0 in DONE; no overlap of input acceptance with output hold.

Latency:
- Number of rising edges from the accepting edge to out_valid high = number of BUSY cycles k.
- k = WIDTH/BPC without early exit. Minimum k = 1, e.g. b=0 with EARLY_EXIT=1.

Edge cases:
- Width rules: accumulation is 2*WIDTH wide and never overflows for unsigned magnitudes.
- in_valid while not in IDLE is ignored; the upstream holds it per the handshake.
- out_ready high while out_valid is low has no effect.
- Reset mid-BUSY or mid-DONE returns to the reset values immediately; the in-flight result is lost.
- Illegal parameters (BPC not in {1,2,4}, WIDTH % BPC != 0, WIDTH < 2) trigger an elaboration-time $error.

Decomposition:
- Package seq_mult_pkg holds:
  - the state enum (IDLE/BUSY/DONE)
  - function abs_mag(value, signed_mode)
  - function steps(WIDTH, BPC) = WIDTH/BPC
  - counter width $clog2(WIDTH/BPC+1)
- Sub-module seq_mult_pp: combinational partial-product generator computing the BPC-bit digit times the 2*WIDTH shifted multiplicand, as a sum of shifted gated copies. It is reused across BPC values.
- FSM, registers and sign fix-up stay in the top.

Test Plan:
- WIDTH=32, BPC=1, EARLY_EXIT=0, unsigned a=b=0xFFFFFFFF -> product 0xFFFFFFFE00000001; out_valid exactly 32 edges after the accept edge; in_ready=0 throughout.
- Signed, WIDTH=32, a=-3 (0xFFFFFFFD), b=5 -> product 0xFFFFFFFFFFFFFFF1. Then signed a=b=0x80000000 -> product 0x4000000000000000.
- EARLY_EXIT=1, BPC=1, a=0x1234, b=3 -> product 0x369C after 2 BUSY cycles. b=0 -> product 0 after 1 BUSY cycle.
- BPC=4, WIDTH=16, unsigned a=0xABCD, b=0x1234 -> product 0x0C374FA4 in 4 BUSY cycles (EARLY_EXIT=0).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> product and out_valid stable, in_ready=0, new in_valid ignored. out_ready=1 -> next cycle IDLE, in_ready=1.
- Reset during BUSY at cnt=10 -> out_valid=0, product=0, busy=0, in_ready=1 asynchronously. A new operation afterwards completes correctly.
